// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
package fifo_pkg;

  // Pointer width: one address bit per entry index plus a wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One-cycle error pulses for rejected requests.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between the FIFO and its producer/consumer.
interface sync_fifo_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  import fifo_pkg::*;

  localparam int CW = ptr_w(DEPTH);

  logic             write;
  logic [WIDTH-1:0] wdata;
  logic             read;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write, wdata, read,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write, wdata, read,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ptr_ctrl.sv
// Pointer, acceptance and status-flag control for the FIFO.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int PW       = ptr_w(DEPTH),
  localparam int AW       = PW - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic          read,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output err_t          err
);

  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Flags and acceptance decoded from registered pointers; a read frees a
  // slot in the same cycle, so a write into a full FIFO is accepted with it.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count        = wr_ptr - rd_ptr;
    almost_full  = (count >= AF_L);
    almost_empty = (count <= AE_L);
    rd_en        = read & ~empty;
    wr_en        = write & (~full | rd_en);
    waddr        = wr_ptr[AW-1:0];
    raddr        = rd_ptr[AW-1:0];
  end

  // Pointers advance on accepted requests and wrap through 2^PW naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Rejected requests raise a pulse for exactly the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= '0;
    end else begin
      err.overflow  <= write & ~wr_en;
      err.underflow <= read & ~rd_en;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: register-array storage plus registered read
// port, with pointer/flag control in fifo_ptr_ctrl.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                clk,
  input  logic                reset,
  sync_fifo_param_if.slave    bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  err_t             err;
  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .write        (bus.write),
    .read         (bus.read),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .waddr        (waddr),
    .raddr        (raddr),
    .count        (bus.count),
    .full         (bus.full),
    .empty        (bus.empty),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty),
    .err          (err)
  );

  // Storage: written only on an accepted write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= bus.wdata;
  end

  // Stage p1: popped word and its valid; rdata holds when nothing is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rdata_p1 <= mem[raddr];
    end
  end

  assign bus.rdata     = rdata_p1;
  assign bus.rvalid    = vld_p1;
  assign bus.overflow  = err.overflow;
  assign bus.underflow = err.underflow;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the general-width, general-depth successor to the fixed 16-bit, 4-entry detector FIFO. It buffers data words between pipeline stages of the neutron-detector datapath, for example between the feature extractor and the inference core. It adds an occupancy count, programmable almost-full and almost-empty flags, a registered read-data valid, and one-cycle overflow/underflow error pulses.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of 2, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL
- AW (derived), $clog2(DEPTH), address width

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- write  in  1  write request
- wdata  in  WIDTH  write data, sampled with write
- read  in  1  read request
- rdata  out  WIDTH  read data, registered
- rvalid  out  1  rdata holds the word popped on the previous cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×WIDTH register array, written only on an accepted write.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low AW bits are equal.
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Acceptance, evaluated on pre-edge state:
  - rd_acc = read & ~empty
  - wr_acc = write & (~full | rd_acc)
- Write and read at the same time:
  - When full, both are accepted and count is unchanged.
  - When empty, the read is rejected (underflow pulses) and the write is accepted.
- Rejected write: memory and pointers are unchanged; overflow = 1 for exactly the next cycle.
- Rejected read: pointers are unchanged; underflow = 1 for the next cycle; rvalid = 0.
- Pointers wrap naturally through 2^(AW+1). No special case is needed at the DEPTH boundary.
- Status flags are decoded combinationally from the registered pointers. They are therefore valid from the cycle after each edge and never glitch relative to clk.
- rdata holds its last value when no read is accepted. It is not cleared.

## Timing
- Reset (asynchronous assert; release is synchronised outside this block):
  - pointers = 0, count = 0, empty = 1, almost_empty = 1
  - full = 0, almost_full = 0 (unless AF_LEVEL = 0)
  - rvalid = 0, overflow = 0, underflow = 0, rdata = 0
- Reset mid-operation discards all contents immediately. Stored memory words need not be cleared.
- Write latency: a word written at edge N is readable (empty deasserts) after edge N.
- Read latency: read accepted at edge N, then rdata/rvalid valid after edge N (one cycle). rvalid is high for one cycle per accepted read.
- Back-to-back reads at full rate return consecutive words in order.
- Throughput: one write plus one read per cycle, sustained.

## Structure
- Package fifo_pkg:
  - function ptr_w(depth) returning $clog2(depth)+1
  - typedef for the error-pulse struct {overflow, underflow}
- Sub-module fifo_ptr_ctrl:
  - holds the pointers, acceptance logic, count and flags
  - outputs waddr, raddr, wr_en, rd_en
- Top level: the memory array plus the rdata/rvalid register.
- Parameter checks via elaboration-time assertions:
  - DEPTH is a power of 2
  - AE_LEVEL < AF_LEVEL ≤ DEPTH

## Test plan
- Reset, then 4 writes (DEPTH=4, WIDTH=16): data 0x1111, 0x2222, 0x3333, 0x4444. Expect full = 1, count = 4, almost_full = 1 from count 3.
- Fifth write 0xDEAD while full, no read: overflow pulses for 1 cycle; count stays 4; subsequent reads return 0x1111..0x4444 in order with rvalid = 1, then empty = 1.
- Read while empty: underflow pulses for 1 cycle; rvalid = 0; count stays 0.
- Simultaneous read+write when full (count=4): both accepted; count stays 4; the oldest word appears on rdata the next cycle.
- Simultaneous read+write when empty: write accepted, underflow = 1, count = 1.
- Wrap: 20 cycles of streamed write+read with an incrementing pattern. Expect an in-order, loss-free output and count ≤ 1 throughout. Assert reset mid-stream: next cycle count = 0, empty = 1, rvalid = 0.
